// File: rtl/led_shift_driver.sv
// led_shift_driver: serialises a parallel word onto a 74HC595-style chain; `LED_SHIFT_AUTO_REFRESH_EN adds change-triggered refresh
module led_shift_driver #(
  parameter int DATA_W    = 16,
  parameter int CLK_DIV   = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] data,
  output logic              busy,
  output logic              done,
  output logic              led_clk,
  output logic              led_pen,
  output logic              led_dat
);
  localparam int CW = $clog2(DATA_W + 1);
  localparam int DW = $clog2(CLK_DIV + 1);
  typedef enum logic [2:0] {IDLE, SHIFT_LO, SHIFT_HI, LATCH, DONE} state_t;
  state_t            state;
  logic [DATA_W-1:0] sr;
  logic [DATA_W-1:0] sr_next;
  logic [CW-1:0]     cnt;
  logic [DW-1:0]     div;
  logic              go;
  logic              tick;
  function automatic logic first_bit(input logic [DATA_W-1:0] w);
    return MSB_FIRST ? w[DATA_W-1] : w[0];
  endfunction
  assign tick    = div == DW'(CLK_DIV - 1);
  assign sr_next = MSB_FIRST ? sr << 1 : sr >> 1;
`ifdef LED_SHIFT_AUTO_REFRESH_EN
  logic [DATA_W-1:0] last_sent;
  logic [DATA_W-1:0] word;
  assign go = start || data != last_sent;
  // last_sent only advances on a completed latch, so an aborted word is resent after reset
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      last_sent <= '0;
      word      <= '0;
    end else begin
      if (state == IDLE && go) word <= data;
      if (state == DONE) last_sent <= word;
    end
`else
  assign go = start;
`endif
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state   <= IDLE;
      sr      <= '0;
      cnt     <= '0;
      div     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      led_clk <= 1'b0;
      led_pen <= 1'b0;
      led_dat <= 1'b0;
    end else begin
      case (state)
        IDLE: if (go) begin
          sr      <= data;
          cnt     <= CW'(DATA_W);
          div     <= '0;
          busy    <= 1'b1;
          led_dat <= first_bit(data);
          state   <= SHIFT_LO;
        end
        SHIFT_LO: begin
          div <= tick ? '0 : div + 1'b1;
          if (tick) begin
            led_clk <= 1'b1;
            state   <= SHIFT_HI;
          end
        end
        SHIFT_HI: begin
          div <= tick ? '0 : div + 1'b1;
          if (tick) begin
            sr      <= sr_next;
            cnt     <= cnt - 1'b1;
            led_clk <= 1'b0;
            led_dat <= cnt == CW'(1) ? 1'b0 : first_bit(sr_next);
            led_pen <= cnt == CW'(1);
            state   <= cnt == CW'(1) ? LATCH : SHIFT_LO;
          end
        end
        LATCH: begin
          div <= tick ? '0 : div + 1'b1;
          if (tick) begin
            led_pen <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_led_shift_driver.sv
// tb_led_shift_driver: directed bench with bit scoreboards for a default instance and an 8-bit LSB-first divide-by-1 instance
module tb_led_shift_driver;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic [15:0] data_a = '0;
  logic [7:0]  data_b = '0;
  logic        busy_a, done_a, led_clk_a, led_pen_a, led_dat_a;
  logic        busy_b, done_b, led_clk_b, led_pen_b, led_dat_b;
  int          tests = 0, fails = 0;
  logic        qa[$], qb[$];
  logic        pa = 1'b0, pb = 1'b0;
  logic        pen_seen_a = 1'b0;
  int          done_cnt_a = 0;

  led_shift_driver dut_a (
    .clk(clk), .rst(rst), .start(start_a), .data(data_a),
    .busy(busy_a), .done(done_a), .led_clk(led_clk_a), .led_pen(led_pen_a), .led_dat(led_dat_a)
  );

  led_shift_driver #(.DATA_W(8), .CLK_DIV(1), .MSB_FIRST(1'b0)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .data(data_b),
    .busy(busy_b), .done(done_b), .led_clk(led_clk_b), .led_pen(led_pen_b), .led_dat(led_dat_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bits are scored where the external chain would sample them: on each led_clk rise
  always @(negedge clk) begin
    if (led_clk_a && !pa) begin
      chk("a_bit_expected", 32'(qa.size() != 0), 32'd1);
      if (qa.size() != 0) chk("a_bit", 32'(led_dat_a), 32'(qa.pop_front()));
    end
    if (led_clk_b && !pb) begin
      chk("b_bit_expected", 32'(qb.size() != 0), 32'd1);
      if (qb.size() != 0) chk("b_bit", 32'(led_dat_b), 32'(qb.pop_front()));
    end
    pa = led_clk_a;
    pb = led_clk_b;
    if (led_pen_a) pen_seen_a = 1'b1;
    if (done_a) done_cnt_a++;
    chk("a_pen_clk_excl", 32'(led_pen_a & led_clk_a), 32'd0);
    chk("b_pen_clk_excl", 32'(led_pen_b & led_clk_b), 32'd0);
  end

  task automatic push_a(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) qa.push_back(w[i]);
  endtask

  task automatic push_b(input logic [7:0] w);
    for (int i = 0; i < 8; i++) qb.push_back(w[i]);
  endtask

  task automatic xfer_a(input logic [15:0] w, input bit poke);
    data_a = w;
    start_a = 1'b1;
    push_a(w);
    done_cnt_a = 0;
    for (int n = 1; n <= 136; n++) begin
      @(negedge clk);
      start_a = 1'b0;
      if (poke && (n == 5 || n == 50 || n == 133)) begin
        start_a = 1'b1;
        data_a = 16'hFFFF;
      end
      if (poke && n == 134) data_a = w;
      chk("a_busy", 32'(busy_a), 32'(n <= 133));
      chk("a_done", 32'(done_a), 32'(n == 133));
      chk("a_pen", 32'(led_pen_a), 32'(n >= 129 && n <= 132));
      chk("a_clk", 32'(led_clk_a), n <= 128 ? 32'(((n - 1) / 4) % 2) : 32'd0);
    end
    chk("a_all_bits_sent", 32'(qa.size()), 32'd0);
    chk("a_done_once", 32'(done_cnt_a), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    data_a = 16'hBEEF; start_a = 1'b1; data_b = 8'h5A; start_b = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_out_a", 32'({busy_a, done_a, led_clk_a, led_pen_a, led_dat_a}), 32'd0);
    chk("rst_out_b", 32'({busy_b, done_b, led_clk_b, led_pen_b, led_dat_b}), 32'd0);
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; data_a = '0; data_b = '0;
    repeat (200) begin
      @(negedge clk);
      chk("idle_out_a", 32'({busy_a, done_a, led_clk_a, led_pen_a, led_dat_a}), 32'd0);
      chk("idle_out_b", 32'({busy_b, done_b, led_clk_b, led_pen_b, led_dat_b}), 32'd0);
    end
    xfer_a(16'hA5C3, 1'b0);
    xfer_a(16'h3C5A, 1'b1);
    data_a = 16'h5AA5;
    start_a = 1'b1;
    push_a(16'h5AA5);
    pen_seen_a = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      start_a = 1'b0;
    end
    chk("pre_abort_busy", 32'({busy_a, led_clk_a, led_dat_a}), 32'b111);
    #2 rst = 1'b0;
    data_b = '0;
    #1;
    chk("abort_out_a", 32'({busy_a, done_a, led_clk_a, led_pen_a, led_dat_a}), 32'd0);
    chk("abort_no_pen", 32'(pen_seen_a), 32'd0);
    qa.delete();
    @(negedge clk);
    data_a = 16'h0F0F;
    @(negedge clk);
    rst = 1'b1;
    xfer_a(16'h0F0F, 1'b0);
    data_b = 8'h01;
    start_b = 1'b1;
    push_b(8'h01);
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      start_b = 1'b0;
      chk("b_busy", 32'(busy_b), 32'(n <= 18));
      chk("b_done", 32'(done_b), 32'(n == 18));
      chk("b_pen", 32'(led_pen_b), 32'(n == 17));
      chk("b_clk", 32'(led_clk_b), n <= 16 ? 32'((n - 1) % 2) : 32'd0);
    end
    chk("b_all_bits_sent", 32'(qb.size()), 32'd0);
`ifdef LED_SHIFT_AUTO_REFRESH_EN
    @(negedge clk);
    rst = 1'b0; data_a = '0; data_b = '0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("auto_idle_same", 32'(busy_a), 32'd0);
    data_a = 16'h0001;
    push_a(16'h0001);
    done_cnt_a = 0;
    @(negedge clk);
    chk("auto_start", 32'(busy_a), 32'd1);
    repeat (500) @(negedge clk);
    chk("auto_done_once", 32'(done_cnt_a), 32'd1);
    chk("auto_idle_after", 32'(busy_a), 32'd0);
    chk("auto_all_bits_sent", 32'(qa.size()), 32'd0);
`else
    @(negedge clk);
    data_a = 16'h1234;
    repeat (20) begin
      @(negedge clk);
      chk("no_auto_start", 32'(busy_a), 32'd0);
    end
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
